// File: rtl/fetch_stage.sv
// fetch_stage: RV32I IF stage holding the PC and the IF/ID pipeline register
module fetch_stage #(
    parameter int              ADDR_WIDTH = 10,
    parameter int              DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_data_i,
    output logic [DATA_WIDTH-1:0] pc_f_o,
    output logic [DATA_WIDTH-1:0] instr_d_o,
    output logic [DATA_WIDTH-1:0] pc_d_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_d_o,
    output logic                  valid_d_o,
    output logic [31:0]           fetch_count_o
);
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_n;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] target_aligned;
    logic                  load;

    assign pc_plus4       = pc_q + DATA_WIDTH'(4);
    assign target_aligned = redirect_target_i & ~DATA_WIDTH'(3);
    assign load           = !flush_i && !stall_i;
    assign imem_addr_o    = pc_q[ADDR_WIDTH-1:0];
    assign pc_f_o         = pc_q;

    // next PC: a redirect wins over a stall so a resolved branch is never lost
    always_comb begin
        pc_n = redirect_i ? target_aligned : stall_i ? pc_q : pc_plus4;
    end

    // PC register
    always_ff @(posedge clk_i) begin
        if (rst_i) pc_q <= RESET_PC;
        else       pc_q <= pc_n;
    end

    // IF/ID register: flush inserts a bubble but keeps the PC fields, stall holds everything
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_d_o    <= NOP_INSTR;
            pc_d_o       <= '0;
            pc_plus4_d_o <= '0;
            valid_d_o    <= 1'b0;
        end else if (flush_i) begin
            instr_d_o    <= NOP_INSTR;
            valid_d_o    <= 1'b0;
        end else if (!stall_i) begin
            instr_d_o    <= imem_data_i;
            pc_d_o       <= pc_q;
            pc_plus4_d_o <= pc_plus4;
            valid_d_o    <= 1'b1;
        end
    end

    // count of real instructions loaded into IF/ID
    always_ff @(posedge clk_i) begin
        if (rst_i)     fetch_count_o <= '0;
        else if (load) fetch_count_o <= fetch_count_o + 32'd1;
    end
endmodule
